dense_argmax: RTL and testbench
===============================

Name: dense_argmax

Overview:
- Consumer at the output end of the dense layer's serial result stream.
- Accepts OUT_COUNT signed scores, one per handshake beat, and stores them in an internal score file.
- Tracks the running maximum and reports the winning class index (MNIST digit 0..9) plus its score.
- The stored scores stay readable until the next frame starts; they are used for debug and softmax-free readout.

Parameters:
- OUT_COUNT, 10, number of scores per frame (classes).
- DATA_SIZE, 16, width of each signed two's-complement score.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; begins a new frame (honoured only in IDLE).
- clear  in  1  synchronous abort; returns to IDLE, discards the partial frame.
- dataValid  in  1  producer has a score on dataIn.
- dataIn  in  DATA_SIZE  signed score.
- dataReady  out  1  block accepts a beat this cycle.
- busy  out  1  high in COLLECT and DONE.
- done  out  1  one-cycle pulse when the result is valid.
- classIdx  out  $clog2(OUT_COUNT)  index of the maximum score.
- maxValue  out  DATA_SIZE  maximum score value.
- scoreAdr  in  $clog2(OUT_COUNT)  readback address.
- scoreData  out  DATA_SIZE  combinational readback of score file[scoreAdr].

Behaviour:
- Clock and reset: one clock, clk; reset port rst is synchronous and active-low. rst sampled low at a rising edge forces:
  - state to IDLE, beat counter to 0;
  - dataReady, busy, done, classIdx, maxValue to 0;
  - score file entries to 0.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - dataReady=0, busy=0.
  - start=1 -> COLLECT; beat counter=0.
  - dataValid is ignored.
- COLLECT:
  - dataReady=1, busy=1.
  - A beat is accepted when dataValid&&dataReady at the rising edge:
    - score[cnt] <= dataIn;
    - if cnt==0 or $signed(dataIn) > runningMax, then runningMax <= dataIn and runningIdx <= cnt;
    - cnt increments.
  - Beat at cnt==OUT_COUNT-1 -> DONE next cycle.
  - start is ignored while in COLLECT.
- DONE:
  - Lasts exactly one cycle; dataReady=0, busy=1, done=1.
  - classIdx and maxValue are loaded from runningIdx and runningMax on entry, so they are valid while done=1.
  - Next state IDLE.
- Latency: done is high in the cycle after the edge that accepted the last beat.
- Result hold: classIdx and maxValue hold until the next DONE; they are unchanged by clear and by a new start.
- Ties: the comparison is strict, so the lowest index wins.
- Arithmetic: signed comparison at full DATA_SIZE width; no saturation needed.
- Gaps: dataValid=0 mid-frame stalls the counter without limit.
- clear:
  - Priority: below rst, above start and above beat acceptance in the same cycle.
  - From any state -> IDLE; done is not asserted.
  - Score file entries already written are kept.
- start and clear in the same cycle in IDLE: clear wins, so the block stays in IDLE.
- Readback: scoreData is combinational from the score file. A write and a read of the same address in the same cycle returns the old value.
- Counter: wraps to 0 on entering DONE; never exceeds OUT_COUNT-1.

Decomposition:
- Shared header/package holds the state encoding localparams (IDLE=0, COLLECT=1, DONE=2) and a CLASS_W = $clog2(OUT_COUNT) constant reused by the dense datapath.
- The beat counter reuses the existing LoopCounter #(OUT_COUNT) (en = accepted beat, clr = clear|start, co = last beat).
- The comparator/argmax register pair stays inline.
- No other sub-module.

Test Plan:
- Frame with scores 3,-5,7,2,0,7,1,-1,4,6 -> done one cycle after 10th beat; classIdx=2 (tie with idx5 goes to lower index); maxValue=7.
- All scores negative: -100,-20,-300,-20,-50,-99,-1000,-21,-30,-40 -> classIdx=1, maxValue=-20 (signed compare; 0x8000-style values handled).
- dataValid toggling every other cycle, scores 0..9 ascending -> done after 10 accepted beats only; classIdx=9, maxValue=9; scoreAdr sweep 0..9 returns 0..9.
- clear asserted after 5 beats -> no done, busy=0 next cycle; previous classIdx/maxValue unchanged; a new full frame then completes correctly.
- rst low asserted for one edge in mid-COLLECT -> all outputs 0, state IDLE; start with no rst then functions normally. Also: start while busy is ignored (beat count unaffected).

Source files
------------

// File: rtl/dense_argmax_pkg.sv
// Shared constants and state encoding for the dense-layer argmax consumer.
package dense_argmax_pkg;

    localparam int OUT_COUNT_DEF = 10;
    localparam int DATA_SIZE_DEF = 16;
    localparam int CLASS_W       = $clog2(OUT_COUNT_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/dense_argmax_loop_counter.sv
// Modulo-N beat counter; co flags the enabled beat that wraps to zero.
module LoopCounter #(
    parameter int N = 10,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         co
);

    logic last;

    assign last = (cnt == W'(N - 1));
    assign co   = en && last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/dense_argmax.sv
// Collects one frame of signed scores, keeps them readable and reports the
// index and value of the strict maximum (lowest index wins ties).
module dense_argmax
    import dense_argmax_pkg::*;
#(
    parameter int OUT_COUNT = OUT_COUNT_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         clear,
    input  logic                         dataValid,
    input  logic signed [DATA_SIZE-1:0]  dataIn,
    output logic                         dataReady,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(OUT_COUNT)-1:0] classIdx,
    output logic signed [DATA_SIZE-1:0]  maxValue,
    input  logic [$clog2(OUT_COUNT)-1:0] scoreAdr,
    output logic signed [DATA_SIZE-1:0]  scoreData
);

    localparam int CW = $clog2(OUT_COUNT);

    state_t state;
    state_t state_nx;

    logic [CW-1:0] cnt;
    logic          last_beat;
    logic          accept;
    logic          cnt_clr;
    logic          take;

    logic signed [DATA_SIZE-1:0] scores [OUT_COUNT];
    logic signed [DATA_SIZE-1:0] run_max;
    logic signed [DATA_SIZE-1:0] cand_max;
    logic [CW-1:0]               run_idx;
    logic [CW-1:0]               cand_idx;

    // clear outranks beat acceptance, so an aborted beat never lands
    assign accept  = dataValid && dataReady && !clear;
    assign cnt_clr = clear || (start && state == IDLE);

    LoopCounter #(
        .N (OUT_COUNT),
        .W (CW)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .clr (cnt_clr),
        .cnt (cnt),
        .co  (last_beat)
    );

    always_comb begin
        state_nx  = state;
        dataReady = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = COLLECT;
            end
            COLLECT: begin
                dataReady = 1'b1;
                busy      = 1'b1;
                if (last_beat) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Candidate includes the current beat so the last beat can win
    assign take     = (cnt == '0) || (dataIn > run_max);
    assign cand_max = take ? dataIn : run_max;
    assign cand_idx = take ? cnt : run_idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < OUT_COUNT; i++) scores[i] <= '0;
            run_max  <= '0;
            run_idx  <= '0;
            classIdx <= '0;
            maxValue <= '0;
        end else if (accept) begin
            scores[cnt] <= dataIn;
            run_max     <= cand_max;
            run_idx     <= cand_idx;
            if (last_beat) begin
                classIdx <= cand_idx;
                maxValue <= cand_max;
            end
        end
    end

    assign scoreData = ({1'b0, scoreAdr} < (CW + 1)'(OUT_COUNT))
                     ? scores[scoreAdr] : '0;

endmodule

// File: tb/tb_dense_argmax.sv
// Table-driven bench for dense_argmax with a done-triggered scoreboard.
module tb_dense_argmax;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               clear = 1'b0;
    logic               dataValid = 1'b0;
    logic signed [15:0] dataIn = '0;
    logic [3:0]         scoreAdr = '0;
    logic               dataReady;
    logic               busy;
    logic               done;
    logic [3:0]         classIdx;
    logic signed [15:0] maxValue;
    logic signed [15:0] scoreData;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] idx;
        logic [15:0] mx;
    } res_t;

    typedef struct packed {
        logic [9:0][15:0] s;
        logic [3:0]       idx;
        logic [15:0]      mx;
        logic             gap;
    } vec_t;

    res_t sbq[$];
    vec_t tbl[6];
    int   sc[6][10];
    int   eidx[6];
    int   emx[6];
    bit   egap[6];

    dense_argmax dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .dataValid (dataValid),
        .dataIn    (dataIn),
        .dataReady (dataReady),
        .busy      (busy),
        .done      (done),
        .classIdx  (classIdx),
        .maxValue  (maxValue),
        .scoreAdr  (scoreAdr),
        .scoreData (scoreData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && done) begin
            res_t r;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got=1 want=0 t=%0t", $time);
            end else begin
                r = sbq.pop_front();
                chk("done_idx", {12'b0, classIdx}, r.idx);
                chk("done_max", maxValue, r.mx);
            end
        end
    end

    task automatic run_frame(input vec_t v, input bit early_start);
        res_t r;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (v.gap) begin
                dataValid = 1'b0;
                dataIn    = 16'sh7fff;
                tick;
            end
            dataValid = 1'b1;
            dataIn    = v.s[i];
            if (early_start && i == 4) start = 1'b1;
            if (i == 9) begin
                r.idx = {12'b0, v.idx};
                r.mx  = v.mx;
                sbq.push_back(r);
            end
            tick;
            start = 1'b0;
        end
        dataValid = 1'b0;
        chk("done_latency", {15'b0, done}, 16'd1);
        chk("busy_in_done", {15'b0, busy}, 16'd1);
        chk("ready_in_done", {15'b0, dataReady}, 16'd0);
        tick;
        chk("done_pulse", {15'b0, done}, 16'd0);
        chk("busy_after", {15'b0, busy}, 16'd0);
        for (int a = 0; a < 10; a++) begin
            scoreAdr = 4'(a);
            #1;
            chk("readback", scoreData, v.s[a]);
        end
    endtask

    initial begin
        vec_t v;
        sc = '{
            '{3, -5, 7, 2, 0, 7, 1, -1, 4, 6},
            '{-100, -20, -300, -20, -50, -99, -1000, -21, -30, -40},
            '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9},
            '{-32768, -32768, -32768, -32768, -32768,
              -32768, -32768, -32767, -32768, -32768},
            '{-32768, -32768, -32768, -32768, -32768,
              -32768, -32768, -32768, -32768, -32768},
            '{1, 1, 1, 1, 1, 1, 1, 1, 1, 32767}
        };
        eidx = '{2, 1, 9, 7, 0, 9};
        emx  = '{7, -20, 9, -32767, -32768, 32767};
        egap = '{0, 0, 1, 0, 0, 0};
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 10; i++) tbl[k].s[i] = 16'(sc[k][i]);
            tbl[k].idx = 4'(eidx[k]);
            tbl[k].mx  = 16'(emx[k]);
            tbl[k].gap = egap[k];
        end

        rst = 1'b0;
        tick;
        tick;
        chk("rst_ready", {15'b0, dataReady}, 16'd0);
        chk("rst_busy", {15'b0, busy}, 16'd0);
        chk("rst_done", {15'b0, done}, 16'd0);
        chk("rst_idx", {12'b0, classIdx}, 16'd0);
        chk("rst_max", maxValue, 16'd0);
        chk("rst_score", scoreData, 16'd0);
        rst = 1'b1;

        dataValid = 1'b1;
        dataIn    = 16'sd55;
        repeat (3) tick;
        chk("idle_busy", {15'b0, busy}, 16'd0);
        chk("idle_ready", {15'b0, dataReady}, 16'd0);
        chk("idle_noaccept", scoreData, 16'd0);
        dataValid = 1'b0;

        for (int k = 0; k < 6; k++) run_frame(tbl[k], 1'b0);

        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dataValid = 1'b1;
            dataIn    = 16'(100 + i);
            tick;
        end
        dataIn = 16'sd500;
        clear  = 1'b1;
        tick;
        clear     = 1'b0;
        dataValid = 1'b0;
        chk("clr_busy", {15'b0, busy}, 16'd0);
        chk("clr_ready", {15'b0, dataReady}, 16'd0);
        chk("clr_done", {15'b0, done}, 16'd0);
        chk("clr_idx_hold", {12'b0, classIdx}, {12'b0, tbl[5].idx});
        chk("clr_max_hold", maxValue, tbl[5].mx);
        scoreAdr = 4'd0;
        #1;
        chk("clr_kept", scoreData, 16'd100);
        scoreAdr = 4'd5;
        #1;
        chk("clr_noaccept", scoreData, tbl[5].s[5]);
        repeat (2) tick;
        run_frame(tbl[0], 1'b0);

        start = 1'b1;
        clear = 1'b1;
        tick;
        start = 1'b0;
        clear = 1'b0;
        chk("clr_beats_start", {15'b0, busy}, 16'd0);
        tick;
        chk("clr_beats_start2", {15'b0, dataReady}, 16'd0);

        for (int i = 0; i < 10; i++) v.s[i] = 16'(5 - i);
        v.idx = 4'd0;
        v.mx  = 16'd5;
        v.gap = 1'b0;
        run_frame(v, 1'b1);

        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dataValid = 1'b1;
            dataIn    = 16'(9 - i);
            tick;
        end
        dataIn = 16'sd99;
        rst    = 1'b0;
        tick;
        rst       = 1'b1;
        dataValid = 1'b0;
        chk("mrst_busy", {15'b0, busy}, 16'd0);
        chk("mrst_ready", {15'b0, dataReady}, 16'd0);
        chk("mrst_done", {15'b0, done}, 16'd0);
        chk("mrst_idx", {12'b0, classIdx}, 16'd0);
        chk("mrst_max", maxValue, 16'd0);
        scoreAdr = 4'd0;
        #1;
        chk("mrst_score", scoreData, 16'd0);
        run_frame(tbl[1], 1'b0);

        repeat (3) tick;
        chk("sb_drained", 16'(sbq.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
